// File: rtl/rnds_intake_queue.sv
// ---------------------------------------------------------------------------
// rnds_pkg: shared types for the decode -> rename/dispatch (RNDS) handshake.
//   decoded_op_t : decoded instruction record. pc is carried for ordering and
//                  debug; the remaining fields are what rename consumes.
//   BHSR_t       : branch history captured at fetch.
//   LFST_WIDTH   : width of the store-set tag.
// ---------------------------------------------------------------------------
package rnds_pkg;

  localparam int unsigned LFST_WIDTH = 7;
  localparam int unsigned BHSR_WIDTH = 10;

  typedef logic [BHSR_WIDTH-1:0] BHSR_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decoded_op_t;

endpackage

// ---------------------------------------------------------------------------
// rnds_intake_queue
//   Front of the RNDS stage. Accepts up to two decoded instructions per cycle
//   from ID, acknowledges each accepted slot, and buffers them in program
//   order in a circular buffer. The two oldest entries are presented to
//   rename, which may drain up to two per cycle. A flush discards everything.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   flush                         discard all entries, refuse input this cycle
//   decoded_instr0/1, instr0/1_*  intake slots (slot 0 older)
//   instr0_issue / instr1_issue   slot accepted this cycle
//   out0_* / out1_*               oldest / second-oldest entry
//   out0_valid / out1_valid       count >= 1 / count >= 2
//   out0_take / out1_take         rename consumes the presented entry
//   count                         registered occupancy
//
// DEPTH must be a power of two and at least 4; pointers wrap by truncation.
// ---------------------------------------------------------------------------
module rnds_intake_queue
  import rnds_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,

  input  decoded_op_t               decoded_instr0,
  input  decoded_op_t               decoded_instr1,
  input  logic                      instr0_valid,
  input  logic                      instr1_valid,
  input  BHSR_t                     instr0_BHSR,
  input  BHSR_t                     instr1_BHSR,
  input  logic [LFST_WIDTH-1:0]     instr0_store_set_id,
  input  logic [LFST_WIDTH-1:0]     instr1_store_set_id,
  output logic                      instr0_issue,
  output logic                      instr1_issue,

  output decoded_op_t               out0_op,
  output decoded_op_t               out1_op,
  output BHSR_t                     out0_BHSR,
  output BHSR_t                     out1_BHSR,
  output logic [LFST_WIDTH-1:0]     out0_store_set_id,
  output logic [LFST_WIDTH-1:0]     out1_store_set_id,
  output logic                      out0_valid,
  output logic                      out1_valid,
  input  logic                      out0_take,
  input  logic                      out1_take,

  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Entry storage (not reset: contents only matter while counted valid)
  decoded_op_t             r_op_mem   [DEPTH];
  BHSR_t                   r_bhsr_mem [DEPTH];
  logic [LFST_WIDTH-1:0]   r_ssid_mem [DEPTH];

  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic [CW-1:0]           w_free;
  logic [PW-1:0]           w_wr_ptr1;
  logic [PW-1:0]           w_rd_ptr1;
  logic                    w_push0;
  logic                    w_push1;
  logic                    w_pop0;
  logic                    w_pop1;
  logic [1:0]              w_push_n;
  logic [1:0]              w_pop_n;
  logic [CW-1:0]           w_count_next;

  // Free space comes only from the registered count, so acceptance never
  // depends on this cycle's takes (no take -> issue combinational path).
  assign w_free    = CW'(DEPTH) - r_count;
  assign w_wr_ptr1 = r_wr_ptr + PW'(1);
  assign w_rd_ptr1 = r_rd_ptr + PW'(1);

  // Slot 1 is only accepted alongside slot 0; a lone slot-1 valid is ignored.
  assign w_push0 = !rst && !flush && instr0_valid && (w_free >= CW'(1));
  assign w_push1 = !rst && !flush && instr0_valid && instr1_valid &&
                   (w_free >= CW'(2));

  assign instr0_issue = w_push0;
  assign instr1_issue = w_push1;

  assign out0_valid = (r_count >= CW'(1));
  assign out1_valid = (r_count >= CW'(2));

  // out1_take only counts when the older entry is popped in the same cycle.
  assign w_pop0 = out0_take && out0_valid;
  assign w_pop1 = w_pop0 && out1_take && out1_valid;

  assign w_push_n = {1'b0, w_push0} + {1'b0, w_push1};
  assign w_pop_n  = {1'b0, w_pop0}  + {1'b0, w_pop1};

  assign w_count_next = r_count + CW'(w_push_n) - CW'(w_pop_n);

  // Read side: oldest two entries
  assign out0_op           = r_op_mem[r_rd_ptr];
  assign out0_BHSR         = r_bhsr_mem[r_rd_ptr];
  assign out0_store_set_id = r_ssid_mem[r_rd_ptr];
  assign out1_op           = r_op_mem[w_rd_ptr1];
  assign out1_BHSR         = r_bhsr_mem[w_rd_ptr1];
  assign out1_store_set_id = r_ssid_mem[w_rd_ptr1];

  assign count = r_count;

  // Pointer and occupancy state; flush wins over any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop_n);
      r_count  <= w_count_next;
    end
  end

  // Entry writes. Issue signals already exclude flush and reset, so no
  // entry is written in a flush cycle.
  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_op_mem[r_wr_ptr]   <= decoded_instr0;
      r_bhsr_mem[r_wr_ptr] <= instr0_BHSR;
      r_ssid_mem[r_wr_ptr] <= instr0_store_set_id;
    end
    if (w_push1) begin
      r_op_mem[w_wr_ptr1]   <= decoded_instr1;
      r_bhsr_mem[w_wr_ptr1] <= instr1_BHSR;
      r_ssid_mem[w_wr_ptr1] <= instr1_store_set_id;
    end
  end

endmodule
